// File: rtl/adder_tree_term_loader.sv
// Producer end of the pipelined fp32 adder tree: packs a scalar stream into
// a term vector, launches it, tracks the fixed tree latency, queues sums.
//
// Ports:
//   clk, rst                       clock, async active-high reset
//   s_tvalid/s_tready/s_tdata/s_tlast  input term stream
//   terms, terms_valid             vector to the tree, launch pulse
//   tree_sum                       tree output S (no valid of its own)
//   m_tvalid/m_tready/m_tdata      output sum FIFO head
module adder_tree_term_loader #(
  parameter int NUM_ELEMENTS = 52,
  parameter int DATA_WIDTH   = 32,
  parameter int TREE_LATENCY = 8,
  parameter int OUT_DEPTH    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic s_tvalid,
  output logic s_tready,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic s_tlast,
  output logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0] terms,
  output logic terms_valid,
  input  logic [DATA_WIDTH-1:0] tree_sum,
  output logic m_tvalid,
  input  logic m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata
);

  localparam int IW = $clog2(NUM_ELEMENTS);
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  typedef enum logic {
    FILL,
    LAUNCH
  } state_t;

  state_t state, state_d;

  logic [IW-1:0] idx;
  logic [TREE_LATENCY-1:0] lat;
  logic [DATA_WIDTH-1:0] mem [OUT_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] ones;
  logic [CW-1:0] outstanding;

  logic accept;
  logic last_slot;
  logic done_beat;
  logic can_launch;
  logic push;
  logic pop;

  assign s_tready  = (state == FILL) && !rst;
  assign accept    = s_tvalid && s_tready;
  assign last_slot = (idx == IW'(NUM_ELEMENTS - 1));
  assign done_beat = accept && (s_tlast || last_slot);

  // Sums still inside the tree plus sums waiting in the FIFO.
  always_comb begin
    ones = '0;
    for (int i = 0; i < TREE_LATENCY; i++)
      ones = ones + CW'(lat[i]);
  end

  assign outstanding = ones + count;
  assign can_launch  = (outstanding < CW'(OUT_DEPTH));

  always_comb begin
    state_d     = state;
    terms_valid = 1'b0;
    unique case (state)
      FILL: begin
        if (done_beat)
          state_d = LAUNCH;
      end
      LAUNCH: begin
        if (can_launch) begin
          terms_valid = 1'b1;
          state_d     = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      idx   <= '0;
    end else begin
      state <= state_d;
      if (accept)
        idx <= done_beat ? '0 : idx + 1'b1;
    end
  end

  // A short vector pads the remaining slots with +0.0 on its last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      terms <= '0;
    end else if (accept) begin
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
        if (IW'(i) == idx)
          terms[i] <= s_tdata;
        else if (s_tlast && (IW'(i) > idx))
          terms[i] <= '0;
      end
    end
  end

  // Tag travels alongside each launched vector; the tap marks S valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lat <= '0;
    else
      lat <= {lat[TREE_LATENCY-2:0], terms_valid};
  end

  assign push     = lat[TREE_LATENCY-1];
  assign m_tvalid = (count != '0);
  assign pop      = m_tvalid && m_tready;
  assign m_tdata  = m_tvalid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= tree_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == AW'(OUT_DEPTH - 1))
                  ? '0 : wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= (rd_ptr == AW'(OUT_DEPTH - 1))
                  ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  full_push_a : assert property (
    @(posedge clk) disable iff (rst)
    !(push && (count == CW'(OUT_DEPTH)))
  );

endmodule
